pll_reset_ctrl: RTL and testbench
=================================

Name: pll_reset_ctrl

Overview:
- Controller side of the PLL rst/locked interface: drives the PLL's active-high rst and consumes its asynchronous locked output.
- Sequences the PLL out of reset, waits for a stable lock, then releases a system reset to downstream logic.
- Detects loss of lock, re-sequences the PLL, retries on lock timeout, and latches a failure flag after repeated timeouts.
- Runs on the free-running 50 MHz reference clock, never on a PLL output, so it operates with the PLL unlocked.

Parameters:
- PLL_RST_CYCLES, 16: refclk cycles pll_rst is held high per reset pulse (>=1).
- LOCK_TIMEOUT, 50000: refclk cycles allowed in WAIT_LOCK before declaring a timeout (1 ms at 50 MHz).
- LOCK_STABLE, 1024: consecutive synchronized-locked-high cycles required before release.
- MAX_RETRIES, 4: timeouts tolerated before entering FAIL (>=1).
- CNT_W, 16: width of the shared cycle counter; must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE).

Ports:
- refclk, in, 1: single clock, 50 MHz reference; all logic is in this domain.
- rst_n, in, 1: asynchronous, active-low reset.
- locked, in, 1: PLL lock indication; asynchronous, passed through a 2-flop synchronizer to give locked_s.
- soft_reset, in, 1: synchronous, 1-cycle request to restart the sequence.
- clr_count, in, 1: synchronous clear of relock_count.
- pll_rst, out, 1: active-high reset to the PLL.
- sys_rst_n, out, 1: active-low system reset for downstream logic; consumers in other domains resynchronize it.
- ready, out, 1: high while in RUN.
- fail, out, 1: high while in FAIL.
- relock_count, out, 8: loss-of-lock events seen in RUN; saturates at 255.

Behaviour:
- All outputs are registered.
- Reset values (rst_n low): state=PLL_RESET, pll_rst=1, sys_rst_n=0, ready=0, fail=0, relock_count=0, retry=0, counter=0, synchronizer flops=0.
- Counter rule: the counter clears on every state entry and increments each cycle while in the state.
- PLL_RESET:
  - pll_rst=1, sys_rst_n=0.
  - After exactly PLL_RST_CYCLES cycles with pll_rst high, go to WAIT_LOCK; pll_rst falls on the same edge.
- WAIT_LOCK:
  - pll_rst=0, sys_rst_n=0.
  - If locked_s=1, go to STABLE.
  - Else, when the counter reaches LOCK_TIMEOUT-1, increment retry. If the new retry equals MAX_RETRIES, go to FAIL; otherwise go to PLL_RESET.
- STABLE:
  - If locked_s=0, return to WAIT_LOCK. The timeout counter restarts; retry is unchanged.
  - After LOCK_STABLE consecutive cycles with locked_s=1, go to RUN and clear retry.
  - sys_rst_n=1 and ready=1 assert on the same edge that enters RUN.
- RUN:
  - sys_rst_n=1, ready=1.
  - On locked_s=0, on the next edge: go to PLL_RESET, sys_rst_n=0, ready=0, pll_rst=1, and relock_count increments, saturating at 255.
  - Worst-case latency from the locked pin falling to sys_rst_n falling is 3 refclk edges.
- FAIL:
  - pll_rst=0, sys_rst_n=0, fail=1.
  - Held indefinitely; only soft_reset or rst_n exits.
- soft_reset (any state):
  - Go to PLL_RESET on the next edge and clear retry and fail.
  - relock_count is not changed.
  - soft_reset has priority over every other transition, including loss of lock in RUN; that cycle does not increment relock_count.
- clr_count:
  - Clears relock_count on the next edge.
  - If an increment occurs in the same cycle, the clear wins and the result is 0.
- rst_n asserted mid-sequence: all registers return to reset values immediately (asynchronous). Sequencing restarts from PLL_RESET on the first edge after deassertion.
- Glitch filter: a locked glitch shorter than one refclk period may or may not be captured. A captured glitch in STABLE restarts stabilization.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2):
- Power-up, lock normal: release rst_n; raise locked 3 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst_n and ready rise 8 cycles after locked_s rises; relock_count=0.
- Glitch during stabilization: locked low for 2 cycles midway through STABLE -> returns to WAIT_LOCK; the stable count restarts; sys_rst_n stays 0 until 8 clean cycles.
- Loss of lock in RUN: drop locked -> sys_rst_n=0 and pll_rst=1 within 3 edges; relock_count=1; re-lock completes normally. Repeat 300 times -> relock_count=255.
- Timeouts: never assert locked -> two 4-cycle pll_rst pulses with 20-cycle waits between them; after the 2nd timeout fail=1, pll_rst=0, and the state holds.
- Recovery from FAIL: pulse soft_reset -> fail=0 next edge; pll_rst pulse restarts; relock_count is unchanged.
- Simultaneous events:
  - soft_reset with locked drop in RUN -> relock_count unchanged.
  - clr_count with locked drop in RUN -> relock_count=0.
  - rst_n asserted mid-WAIT_LOCK -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/pll_reset_ctrl_if.sv
// pll_reset_ctrl_if: reset/lock handshake between the reset controller and a PLL.
//   pll_rst : active-high reset into the PLL, driven by the controller (master)
//   locked  : lock indication from the PLL (slave), asynchronous to refclk
interface pll_reset_ctrl_if;
    logic pll_rst;
    logic locked;

    modport master (output pll_rst, input locked);
    modport slave (input pll_rst, output locked);
endinterface

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: sequences a PLL out of reset, waits for a stable lock, then releases the
// system reset. Re-sequences on loss of lock, retries on lock timeout and latches a failure
// flag after MAX_RETRIES consecutive timeouts. Runs entirely on the free-running refclk.
//   refclk       : 50 MHz reference clock (never a PLL output)
//   rst_n        : asynchronous active-low reset
//   pll          : pll_rst out to the PLL, locked in from the PLL (synchronized internally)
//   soft_reset   : 1-cycle request to restart the sequence; overrides every other transition
//   clr_count    : clears relock_count; wins over a same-cycle increment
//   sys_rst_n    : active-low reset for downstream logic
//   ready        : high while running with a stable lock
//   fail         : high after repeated lock timeouts, until soft_reset or rst_n
//   relock_count : loss-of-lock events seen while running, saturating at 255
module pll_reset_ctrl #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned MAX_RETRIES    = 4,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    pll_reset_ctrl_if.master        pll,
    input  logic                    soft_reset,
    input  logic                    clr_count,
    output logic                    sys_rst_n,
    output logic                    ready,
    output logic                    fail,
    output logic [7:0]              relock_count
);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   RstLast     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees locked_s high is the first stable cycle, so
    // STABLE itself only has to cover the remaining LOCK_STABLE-1 cycles.
    localparam logic [CNT_W-1:0]   StableLast  =
        CNT_W'((LOCK_STABLE >= 2) ? (LOCK_STABLE - 2) : 0);
    localparam logic [RETRY_W-1:0] RetryMax    = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StPllReset,
        StWaitLock,
        StStable,
        StRun,
        StFail
    } state_e;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry;
    logic               locked_meta;
    logic               locked_s;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StPllReset;
            cnt          <= '0;
            retry        <= '0;
            locked_meta  <= 1'b0;
            locked_s     <= 1'b0;
            pll.pll_rst  <= 1'b1;
            sys_rst_n    <= 1'b0;
            ready        <= 1'b0;
            fail         <= 1'b0;
            relock_count <= '0;
        end else begin
            locked_meta <= pll.locked;
            locked_s    <= locked_meta;
            cnt         <= cnt + 1'b1;

            if (soft_reset) begin
                state       <= StPllReset;
                cnt         <= '0;
                retry       <= '0;
                pll.pll_rst <= 1'b1;
                sys_rst_n   <= 1'b0;
                ready       <= 1'b0;
                fail        <= 1'b0;
            end else begin
                unique case (state)
                    StPllReset: begin
                        if (cnt == RstLast) begin
                            state       <= StWaitLock;
                            cnt         <= '0;
                            pll.pll_rst <= 1'b0;
                        end
                    end
                    StWaitLock: begin
                        if (locked_s) begin
                            cnt <= '0;
                            if (LOCK_STABLE <= 1) begin
                                state     <= StRun;
                                retry     <= '0;
                                sys_rst_n <= 1'b1;
                                ready     <= 1'b1;
                            end else begin
                                state <= StStable;
                            end
                        end else if (cnt == TimeoutLast) begin
                            cnt   <= '0;
                            retry <= retry + 1'b1;
                            if (retry + 1'b1 == RetryMax) begin
                                state <= StFail;
                                fail  <= 1'b1;
                            end else begin
                                state       <= StPllReset;
                                pll.pll_rst <= 1'b1;
                            end
                        end
                    end
                    StStable: begin
                        if (!locked_s) begin
                            state <= StWaitLock;
                            cnt   <= '0;
                        end else if (cnt == StableLast) begin
                            state     <= StRun;
                            cnt       <= '0;
                            retry     <= '0;
                            sys_rst_n <= 1'b1;
                            ready     <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (!locked_s) begin
                            state       <= StPllReset;
                            cnt         <= '0;
                            pll.pll_rst <= 1'b1;
                            sys_rst_n   <= 1'b0;
                            ready       <= 1'b0;
                            if (relock_count != 8'hff) begin
                                relock_count <= relock_count + 8'd1;
                            end
                        end
                    end
                    StFail: begin
                        // Counter is free-running here and in RUN; its value is unused.
                    end
                    default: begin
                        state       <= StPllReset;
                        cnt         <= '0;
                        pll.pll_rst <= 1'b1;
                        sys_rst_n   <= 1'b0;
                        ready       <= 1'b0;
                        fail        <= 1'b0;
                    end
                endcase
            end

            if (clr_count) begin
                relock_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: randomized scenario bench for pll_reset_ctrl against a phase-level model.
module tb_pll_reset_ctrl;
    localparam int unsigned PLL_RST_CYCLES = 4;
    localparam int unsigned LOCK_TIMEOUT   = 20;
    localparam int unsigned LOCK_STABLE    = 8;
    localparam int unsigned MAX_RETRIES    = 2;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b1;
    logic       soft_reset = 1'b0;
    logic       clr_count = 1'b0;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [7:0] relock_count;

    pll_reset_ctrl_if pll_if ();

    pll_reset_ctrl #(
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .LOCK_STABLE    (LOCK_STABLE),
        .MAX_RETRIES    (MAX_RETRIES),
        .CNT_W          (16)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll          (pll_if.master),
        .soft_reset   (soft_reset),
        .clr_count    (clr_count),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .fail         (fail),
        .relock_count (relock_count)
    );

    always #10 refclk = ~refclk;

    int checks = 0;
    int errors = 0;

    // Reference model: a named phase, how long we have been in it, how many consecutive
    // synchronized-lock samples were seen, timeout tries and relock events.
    string m_phase;
    int    m_age;
    int    m_run;
    int    m_tries;
    int    m_relocks;
    bit    m_s1;
    bit    m_s2;

    function automatic void model_reset();
        m_phase = "pll_reset";
        m_age = 0;
        m_run = 0;
        m_tries = 0;
        m_relocks = 0;
        m_s1 = 1'b0;
        m_s2 = 1'b0;
    endfunction

    function automatic void model_clock(input bit lk, input bit sr, input bit cc);
        bit ls;
        ls = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        if (sr) begin
            m_phase = "pll_reset";
            m_age = 0;
            m_tries = 0;
        end else if (m_phase == "pll_reset") begin
            m_age++;
            if (m_age == int'(PLL_RST_CYCLES)) begin
                m_phase = "wait_lock";
                m_age = 0;
            end
        end else if (m_phase == "wait_lock") begin
            if (ls) begin
                m_run = 1;
                m_phase = "stable";
                if (m_run >= int'(LOCK_STABLE)) begin
                    m_phase = "run";
                    m_tries = 0;
                end
            end else begin
                m_age++;
                if (m_age == int'(LOCK_TIMEOUT)) begin
                    m_tries++;
                    m_age = 0;
                    m_phase = (m_tries == int'(MAX_RETRIES)) ? "fail" : "pll_reset";
                end
            end
        end else if (m_phase == "stable") begin
            if (!ls) begin
                m_phase = "wait_lock";
                m_age = 0;
            end else begin
                m_run++;
                if (m_run == int'(LOCK_STABLE)) begin
                    m_phase = "run";
                    m_tries = 0;
                end
            end
        end else if (m_phase == "run") begin
            if (!ls) begin
                m_phase = "pll_reset";
                m_age = 0;
                if (m_relocks < 255) m_relocks++;
            end
        end
        if (cc) m_relocks = 0;
    endfunction

    function automatic logic [11:0] exp_outs();
        logic [7:0] rc;
        rc = 8'(m_relocks);
        return {m_phase == "pll_reset", m_phase == "run", m_phase == "run",
                m_phase == "fail", rc};
    endfunction

    function automatic logic [11:0] dut_outs();
        return {pll_if.pll_rst, sys_rst_n, ready, fail, relock_count};
    endfunction

    // One refclk edge: inputs are captured as the DUT sees them, outputs settle by #1.
    task automatic tick();
        bit lk, sr, cc;
        lk = pll_if.locked;
        sr = soft_reset;
        cc = clr_count;
        @(posedge refclk);
        model_clock(lk, sr, cc);
        #1;
    endtask

    task automatic test_reset();
        pll_if.locked = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #3;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_outs() !== 12'h800) begin
                errors++;
                $display("FAIL reset_values: got %h want %h", dut_outs(), 12'h800);
            end
            @(posedge refclk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_power_up();
        int hi, n;
        hi = 0;
        for (int i = 0; i < 20 && pll_if.pll_rst; i++) begin
            hi++;
            tick();
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL power_up_cycle: got %h want %h", dut_outs(), exp_outs());
            end
        end
        checks++;
        if (hi != int'(PLL_RST_CYCLES)) begin
            errors++;
            $display("FAIL pll_rst_width: got %0d want %0d", hi, PLL_RST_CYCLES);
        end
        repeat (3) begin
            tick();
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL power_up_wait: got %h want %h", dut_outs(), exp_outs());
            end
        end
        pll_if.locked = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL power_up_lock: got %h want %h", dut_outs(), exp_outs());
            end
        end while (!ready && n < 40);
        checks++;
        if (n != 2 + int'(LOCK_STABLE)) begin
            errors++;
            $display("FAIL lock_to_ready: got %0d want %0d", n, 2 + LOCK_STABLE);
        end
        checks++;
        if (relock_count !== 8'd0) begin
            errors++;
            $display("FAIL power_up_relock: got %0d want 0", relock_count);
        end
    endtask

    task automatic test_glitch();
        int t, dip, n;
        t = $urandom_range(LOCK_STABLE - 1, 3);
        dip = $urandom_range(3, 1);
        pll_if.locked = 1'b0;
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        n = 0;
        while (pll_if.pll_rst && n < 20) begin
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL glitch_reset: got %h want %h", dut_outs(), exp_outs());
            end
            tick();
            n++;
        end
        pll_if.locked = 1'b1;
        repeat (t) begin
            tick();
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL glitch_stable: got %h want %h", dut_outs(), exp_outs());
            end
        end
        pll_if.locked = 1'b0;
        repeat (dip) tick();
        pll_if.locked = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL glitch_relock: got %h want %h", dut_outs(), exp_outs());
            end
        end while (!ready && n < 40);
        checks++;
        if (n != 2 + int'(LOCK_STABLE)) begin
            errors++;
            $display("FAIL glitch_restart: got %0d want %0d", n, 2 + LOCK_STABLE);
        end
    endtask

    task automatic test_loss_of_lock();
        int n;
        for (int it = 0; it < 300; it++) begin
            repeat ($urandom_range(3, 0)) tick();
            pll_if.locked = 1'b0;
            for (int e = 1; e <= 3; e++) begin
                tick();
                checks++;
                if (dut_outs() !== exp_outs()) begin
                    errors++;
                    $display("FAIL lol_cycle: got %h want %h", dut_outs(), exp_outs());
                end
                if (e == 3) begin
                    checks++;
                    if ({sys_rst_n, ready, pll_if.pll_rst} !== 3'b001) begin
                        errors++;
                        $display("FAIL lol_latency: got %b want 001",
                                 {sys_rst_n, ready, pll_if.pll_rst});
                    end
                end
            end
            if (it == 0) begin
                checks++;
                if (relock_count !== 8'd1) begin
                    errors++;
                    $display("FAIL lol_first_count: got %0d want 1", relock_count);
                end
            end
            repeat ($urandom_range(5, 0)) tick();
            pll_if.locked = 1'b1;
            n = 0;
            do begin
                tick();
                n++;
                checks++;
                if (dut_outs() !== exp_outs()) begin
                    errors++;
                    $display("FAIL lol_relock: got %h want %h", dut_outs(), exp_outs());
                end
            end while (!ready && n < 60);
        end
        checks++;
        if (relock_count !== 8'd255) begin
            errors++;
            $display("FAIL lol_saturate: got %0d want 255", relock_count);
        end
    endtask

    task automatic test_soft_vs_lol();
        int n;
        pll_if.locked = 1'b0;
        repeat (2) tick();
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        checks++;
        if (relock_count !== 8'd255 || {pll_if.pll_rst, ready} !== 2'b10) begin
            errors++;
            $display("FAIL soft_vs_lol: got cnt=%0d rst/rdy=%b want cnt=255 rst/rdy=10",
                     relock_count, {pll_if.pll_rst, ready});
        end
        pll_if.locked = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL soft_relock: got %h want %h", dut_outs(), exp_outs());
            end
        end while (!ready && n < 60);
    endtask

    task automatic test_timeouts();
        int   trans[$];
        int   exp_tr[3];
        int   fail_at;
        logic prev;
        exp_tr = '{PLL_RST_CYCLES, PLL_RST_CYCLES + LOCK_TIMEOUT,
                   2 * PLL_RST_CYCLES + LOCK_TIMEOUT};
        fail_at = -1;
        pll_if.locked = 1'b0;
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        prev = pll_if.pll_rst;
        for (int idx = 1; idx <= 80; idx++) begin
            tick();
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL timeout_cycle: got %h want %h", dut_outs(), exp_outs());
            end
            if (pll_if.pll_rst !== prev) begin
                trans.push_back(idx);
                prev = pll_if.pll_rst;
            end
            if (fail === 1'b1 && fail_at < 0) fail_at = idx;
        end
        checks++;
        if (trans.size() != 3) begin
            errors++;
            $display("FAIL timeout_edges: got %0d edges want 3", trans.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (trans[j] != exp_tr[j]) begin
                    errors++;
                    $display("FAIL timeout_edge_%0d: got %0d want %0d", j, trans[j], exp_tr[j]);
                end
            end
        end
        checks++;
        if (fail_at != 2 * int'(PLL_RST_CYCLES + LOCK_TIMEOUT)) begin
            errors++;
            $display("FAIL fail_time: got %0d want %0d", fail_at,
                     2 * (PLL_RST_CYCLES + LOCK_TIMEOUT));
        end
        checks++;
        if ({fail, pll_if.pll_rst, sys_rst_n} !== 3'b100) begin
            errors++;
            $display("FAIL fail_hold: got %b want 100", {fail, pll_if.pll_rst, sys_rst_n});
        end
    endtask

    task automatic test_fail_recovery();
        int hi, n;
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        checks++;
        if ({fail, pll_if.pll_rst} !== 2'b01 || relock_count !== 8'd255) begin
            errors++;
            $display("FAIL recovery_exit: got fail/rst=%b cnt=%0d want 01 cnt=255",
                     {fail, pll_if.pll_rst}, relock_count);
        end
        hi = 0;
        for (int i = 0; i < 20 && pll_if.pll_rst; i++) begin
            hi++;
            tick();
        end
        checks++;
        if (hi != int'(PLL_RST_CYCLES)) begin
            errors++;
            $display("FAIL recovery_pulse: got %0d want %0d", hi, PLL_RST_CYCLES);
        end
        pll_if.locked = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL recovery_lock: got %h want %h", dut_outs(), exp_outs());
            end
        end while (!ready && n < 60);
    endtask

    task automatic test_clr_vs_lol();
        int n;
        pll_if.locked = 1'b0;
        repeat (2) tick();
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        checks++;
        if (relock_count !== 8'd0 || pll_if.pll_rst !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_lol: got cnt=%0d rst=%b want cnt=0 rst=1",
                     relock_count, pll_if.pll_rst);
        end
        pll_if.locked = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL clr_relock: got %h want %h", dut_outs(), exp_outs());
            end
        end while (!ready && n < 60);
    endtask

    task automatic test_async_reset();
        int n, hi;
        pll_if.locked = 1'b0;
        repeat (3) tick();
        n = 0;
        while (pll_if.pll_rst && n < 20) begin
            tick();
            n++;
        end
        repeat (2) tick();
        checks++;
        if (dut_outs() !== exp_outs() || m_phase != "wait_lock") begin
            errors++;
            $display("FAIL pre_async: got %h want %h in wait_lock", dut_outs(), exp_outs());
        end
        #4;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_outs() !== 12'h800) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", dut_outs(), 12'h800);
        end
        @(posedge refclk);
        #1;
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 20 && pll_if.pll_rst; i++) begin
            hi++;
            tick();
            checks++;
            if (dut_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL restart_cycle: got %h want %h", dut_outs(), exp_outs());
            end
        end
        checks++;
        if (hi != int'(PLL_RST_CYCLES)) begin
            errors++;
            $display("FAIL restart_pulse: got %0d want %0d", hi, PLL_RST_CYCLES);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_glitch();
        test_loss_of_lock();
        test_soft_vs_lol();
        test_timeouts();
        test_fail_recovery();
        test_clr_vs_lol();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
